// File: rtl/uart_frame_decoder_if.sv
// Byte-stream input and object-table output bundle for uart_frame_decoder.
// The receiver side (master) drives the byte bus; the decoder (slave) drives the results.
interface uart_frame_decoder_if;
    logic [7:0]  dataReceived;
    logic        dataAvail;
    logic        objWrite;
    logic [7:0]  objId;
    logic [9:0]  objX;
    logic [9:0]  objY;
    logic [7:0]  objAttr;
    logic        frameErr;
    logic [7:0]  errCount;
    logic [15:0] frameCount;
    logic        busy;

    modport master (
        output dataReceived, dataAvail,
        input  objWrite, objId, objX, objY, objAttr,
        input  frameErr, errCount, frameCount, busy
    );

    modport slave (
        input  dataReceived, dataAvail,
        output objWrite, objId, objX, objY, objAttr,
        output frameErr, errCount, frameCount, busy
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/ID/XH/XL/YH/YL/ATTR/CSUM sprite frames from a toggle-flagged byte
// stream and issues one-cycle object-table writes or frame-error strobes.
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter int         MAX_OBJ   = 64,
    parameter int         TIMEOUT   = 5000
) (
    input logic                 CLOCK,
    input logic                 reset,
    uart_frame_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        S_HUNT, S_ID, S_XH, S_XL, S_YH, S_YL, S_ATTR, S_CSUM
    } state_t;

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          avail_q, avail_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    id_sh_q, id_sh_d;
    logic [1:0]    xh_sh_q, xh_sh_d;
    logic [7:0]    xl_sh_q, xl_sh_d;
    logic [1:0]    yh_sh_q, yh_sh_d;
    logic [7:0]    yl_sh_q, yl_sh_d;
    logic [7:0]    attr_sh_q, attr_sh_d;

    logic          obj_write_q, obj_write_d;
    logic [7:0]    obj_id_q, obj_id_d;
    logic [9:0]    obj_x_q, obj_x_d;
    logic [9:0]    obj_y_q, obj_y_d;
    logic [7:0]    obj_attr_q, obj_attr_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          busy_q, busy_d;

    logic          ev;
    logic          reject;
    logic [7:0]    rx;

    always_comb begin
        state_d     = state_q;
        avail_d     = bus.dataAvail;
        tmo_d       = tmo_q;
        csum_d      = csum_q;
        id_sh_d     = id_sh_q;
        xh_sh_d     = xh_sh_q;
        xl_sh_d     = xl_sh_q;
        yh_sh_d     = yh_sh_q;
        yl_sh_d     = yl_sh_q;
        attr_sh_d   = attr_sh_q;
        obj_write_d = 1'b0;
        obj_id_d    = obj_id_q;
        obj_x_d     = obj_x_q;
        obj_y_d     = obj_y_q;
        obj_attr_d  = obj_attr_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        reject      = 1'b0;
        ev          = bus.dataAvail ^ avail_q;
        rx          = bus.dataReceived;

        if (state_q == S_HUNT) begin
            tmo_d = '0;
            if (ev && rx == SYNC_BYTE) begin
                state_d   = S_ID;
                csum_d    = '0;
                id_sh_d   = '0;
                xh_sh_d   = '0;
                xl_sh_d   = '0;
                yh_sh_d   = '0;
                yl_sh_d   = '0;
                attr_sh_d = '0;
            end
        end else if (ev) begin
            // A byte arriving on the expiry cycle still counts, so ev is tested before the timeout.
            tmo_d = '0;
            unique case (state_q)
                S_ID:   begin id_sh_d   = rx;      csum_d = csum_q ^ rx; state_d = S_XH;   end
                S_XH:   begin xh_sh_d   = rx[1:0]; csum_d = csum_q ^ rx; state_d = S_XL;   end
                S_XL:   begin xl_sh_d   = rx;      csum_d = csum_q ^ rx; state_d = S_YH;   end
                S_YH:   begin yh_sh_d   = rx[1:0]; csum_d = csum_q ^ rx; state_d = S_YL;   end
                S_YL:   begin yl_sh_d   = rx;      csum_d = csum_q ^ rx; state_d = S_ATTR; end
                S_ATTR: begin attr_sh_d = rx;      csum_d = csum_q ^ rx; state_d = S_CSUM; end
                S_CSUM: begin
                    state_d = S_HUNT;
                    if (csum_q == rx && int'(id_sh_q) < MAX_OBJ) begin
                        obj_write_d = 1'b1;
                        obj_id_d    = id_sh_q;
                        obj_x_d     = {xh_sh_q, xl_sh_q};
                        obj_y_d     = {yh_sh_q, yl_sh_q};
                        obj_attr_d  = attr_sh_q;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end else if (tmo_q == TMAX) begin
            state_d = S_HUNT;
            tmo_d   = '0;
            reject  = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (reject) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
        end

        busy_d = (state_d != S_HUNT);
    end

    always_ff @(posedge CLOCK) begin
        if (!reset) begin
            state_q     <= S_HUNT;
            avail_q     <= bus.dataAvail;
            tmo_q       <= '0;
            csum_q      <= '0;
            id_sh_q     <= '0;
            xh_sh_q     <= '0;
            xl_sh_q     <= '0;
            yh_sh_q     <= '0;
            yl_sh_q     <= '0;
            attr_sh_q   <= '0;
            obj_write_q <= 1'b0;
            obj_id_q    <= '0;
            obj_x_q     <= '0;
            obj_y_q     <= '0;
            obj_attr_q  <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            avail_q     <= avail_d;
            tmo_q       <= tmo_d;
            csum_q      <= csum_d;
            id_sh_q     <= id_sh_d;
            xh_sh_q     <= xh_sh_d;
            xl_sh_q     <= xl_sh_d;
            yh_sh_q     <= yh_sh_d;
            yl_sh_q     <= yl_sh_d;
            attr_sh_q   <= attr_sh_d;
            obj_write_q <= obj_write_d;
            obj_id_q    <= obj_id_d;
            obj_x_q     <= obj_x_d;
            obj_y_q     <= obj_y_d;
            obj_attr_q  <= obj_attr_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.objWrite   = obj_write_q;
    assign bus.objId      = obj_id_q;
    assign bus.objX       = obj_x_q;
    assign bus.objY       = obj_y_q;
    assign bus.objAttr    = obj_attr_q;
    assign bus.frameErr   = frame_err_q;
    assign bus.errCount   = err_cnt_q;
    assign bus.frameCount = frame_cnt_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: valid, corrupt, out-of-range, stray-byte,
// timeout, mid-frame reset and error-counter saturation scenarios.
module tb_uart_frame_decoder;

    logic CLOCK = 1'b0;
    logic reset = 1'b0;
    always #5 CLOCK = ~CLOCK;

    uart_frame_decoder_if bus ();

    uart_frame_decoder #(
        .SYNC_BYTE (8'hAA),
        .MAX_OBJ   (64),
        .TIMEOUT   (5000)
    ) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int   wr_hi = 0, wr_rise = 0, err_hi = 0, err_rise = 0, both_cnt = 0;
    logic wr_prev = 1'b0, err_prev = 1'b0;

    always @(negedge CLOCK) begin
        if (bus.objWrite) wr_hi++;
        if (bus.objWrite && !wr_prev) wr_rise++;
        if (bus.frameErr) err_hi++;
        if (bus.frameErr && !err_prev) err_rise++;
        if (bus.objWrite && bus.frameErr) both_cnt++;
        wr_prev  = bus.objWrite;
        err_prev = bus.frameErr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK);
        bus.dataReceived = b;
        bus.dataAvail    = ~bus.dataAvail;
        idle(3);
    endtask

    task automatic send_frame(input logic [7:0] id, xh, xl, yh, yl, attr, cs);
        send_byte(8'hAA);
        send_byte(id);
        send_byte(xh);
        send_byte(xl);
        send_byte(yh);
        send_byte(yl);
        send_byte(attr);
        send_byte(cs);
        idle(2);
    endtask

    initial begin
        bus.dataReceived = 8'h00;
        bus.dataAvail    = 1'b0;
        reset            = 1'b0;
        idle(3);
        // Toggle during reset: must be absorbed, not seen as a byte afterwards.
        bus.dataReceived = 8'hAA;
        bus.dataAvail    = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(3);

        check("rst_objWrite",   bus.objWrite,   0);
        check("rst_frameErr",   bus.frameErr,   0);
        check("rst_errCount",   bus.errCount,   0);
        check("rst_frameCount", bus.frameCount, 0);
        check("rst_busy",       bus.busy,       0);
        check("rst_objId",      bus.objId,      0);
        check("rst_objX",       bus.objX,       0);

        // 05^01^2C^00^C8^03 = E3
        send_byte(8'hAA);
        check("busy_in_frame", bus.busy, 1);
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h2C);
        send_byte(8'h00); send_byte(8'hC8); send_byte(8'h03); send_byte(8'hE3);
        idle(2);
        check("v1_writes",     wr_rise,        1);
        check("v1_errs",       err_rise,       0);
        check("v1_objId",      bus.objId,      5);
        check("v1_objX",       bus.objX,       300);
        check("v1_objY",       bus.objY,       200);
        check("v1_objAttr",    bus.objAttr,    3);
        check("v1_frameCount", bus.frameCount, 1);
        check("v1_errCount",   bus.errCount,   0);
        check("v1_busy",       bus.busy,       0);

        send_frame(8'h05, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 8'hE2);
        check("bad_cs_errs",     err_rise,       1);
        check("bad_cs_writes",   wr_rise,        1);
        check("bad_cs_errCount", bus.errCount,   1);
        check("bad_cs_objId",    bus.objId,      5);
        check("bad_cs_objX",     bus.objX,       300);
        check("bad_cs_fcount",   bus.frameCount, 1);

        // 40^01^2C^00^C8^03 = A6, checksum good but id out of range
        send_frame(8'h40, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 8'hA6);
        check("bad_id_errs",     err_rise,     2);
        check("bad_id_writes",   wr_rise,      1);
        check("bad_id_errCount", bus.errCount, 2);

        // Stray bytes, then a frame carrying AA in the payload; 07^00^AA^01^02^AA = 04
        send_byte(8'h00);
        send_byte(8'h55);
        check("stray_busy", bus.busy, 0);
        send_frame(8'h07, 8'h00, 8'hAA, 8'h01, 8'h02, 8'hAA, 8'h04);
        check("aa_writes",     wr_rise,        2);
        check("aa_errs",       err_rise,       2);
        check("aa_objId",      bus.objId,      7);
        check("aa_objX",       bus.objX,       170);
        check("aa_objY",       bus.objY,       258);
        check("aa_objAttr",    bus.objAttr,    8'hAA);
        check("aa_frameCount", bus.frameCount, 2);

        // Abandoned frame: expiry lands 5000 edges after the last consumed byte.
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01);
        idle(4990);
        check("tmo_pre_busy", bus.busy, 1);
        check("tmo_pre_errs", err_rise, 2);
        idle(20);
        check("tmo_errs",     err_rise,     3);
        check("tmo_errCount", bus.errCount, 3);
        check("tmo_busy",     bus.busy,     0);
        send_frame(8'h05, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 8'hE3);
        check("post_tmo_writes", wr_rise,        3);
        check("post_tmo_fcount", bus.frameCount, 3);
        check("post_tmo_objId",  bus.objId,      5);

        // Reset in the middle of a frame.
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01);
        @(negedge CLOCK);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
        check("mrst_errs",     err_rise,       3);
        check("mrst_busy",     bus.busy,       0);
        check("mrst_fcount",   bus.frameCount, 0);
        check("mrst_errCount", bus.errCount,   0);
        check("mrst_objId",    bus.objId,      0);
        send_frame(8'h05, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 8'hE3);
        check("mrst_writes", wr_rise,        4);
        check("mrst_errs2",  err_rise,       3);
        check("mrst_fcount2", bus.frameCount, 1);
        check("mrst_objY",   bus.objY,       200);

        // Saturation of the error counter.
        for (int i = 0; i < 256; i++)
            send_frame(8'h05, 8'h01, 8'h2C, 8'h00, 8'hC8, 8'h03, 8'h00);
        check("sat_errCount", bus.errCount,   255);
        check("sat_errs",     err_rise,       259);
        check("sat_fcount",   bus.frameCount, 1);
        check("sat_objId",    bus.objId,      5);

        check("write_width", wr_hi,    wr_rise);
        check("err_width",   err_hi,   err_rise);
        check("never_both",  both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
